wb_fetch_master: RTL and testbench

WB_FETCH_MASTER -- requirements
Module: wb_fetch_master

---
 rtl/wb_fetch_master.sv | 189 ++++++++++++++++++
 tb/tb_wb_fetch_master.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_fetch_master.sv
// Pipelined Wishbone burst-read master: issues sequential word reads and streams the
// returned data through a FIFO whose depth also bounds the number of requests in flight.
module wb_fetch_master #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_STEP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [31:0] i_base_addr,
    input  logic [15:0] i_count,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data,
    output logic        o_valid,
    output logic [31:0] o_data,
    input  logic        i_ready
);
    localparam int unsigned PW       = $clog2(DEPTH);
    localparam int unsigned CW       = PW + 1;
    localparam logic [CW:0] Limit    = (CW + 1)'(DEPTH);
    localparam logic [31:0] AddrStep = 32'(ADDR_STEP);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_t;

    state_t        state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic [31:0]   addr_q, addr_d;
    logic [15:0]   rem_q, rem_d;
    logic [CW-1:0] out_q, out_d;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] fcnt_q, fcnt_d;

    logic          accept;
    logic          resp_live;
    logic          ack_cnt;
    logic          err_cnt;
    logic          push;
    logic          pop;
    logic [CW:0]   occ;

    // Responses only count while the cycle is open and something is actually in flight.
    assign accept    = stb_q & ~i_wb_stall;
    assign resp_live = cyc_q & (out_q != '0);
    assign ack_cnt   = resp_live & i_wb_ack & ~i_wb_err;
    assign err_cnt   = resp_live & i_wb_err;
    assign push      = ack_cnt;
    assign pop       = o_valid & i_ready;

    always_comb begin
        fcnt_d = fcnt_q + CW'(push) - CW'(pop);
        wptr_d = wptr_q + PW'(push);
        rptr_d = rptr_q + PW'(pop);
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        out_d   = out_q;
        occ     = '0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    err_d = 1'b0;
                    if (i_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StIssue;
                        busy_d  = 1'b1;
                        cyc_d   = 1'b1;
                        // Leftover words from a previous burst may still fill the FIFO.
                        stb_d   = {1'b0, fcnt_d} < Limit;
                        addr_d  = i_base_addr;
                        rem_d   = i_count;
                    end
                end
            end
            StIssue, StDrain: begin
                if (err_cnt) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    rem_d   = '0;
                    out_d   = '0;
                end else begin
                    out_d = out_q + CW'(accept) - CW'(ack_cnt);
                    if (accept) begin
                        addr_d = addr_q + AddrStep;
                        rem_d  = rem_q - 16'd1;
                    end
                    // Every in-flight request must have a guaranteed FIFO slot for its ack.
                    occ = {1'b0, out_d} + {1'b0, fcnt_d};
                    if (rem_d == '0 && out_d == '0) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                    end else if (rem_d == '0) begin
                        state_d = StDrain;
                        stb_d   = 1'b0;
                    end else begin
                        stb_d = occ < Limit;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            out_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fcnt_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fcnt_q  <= fcnt_d;
            if (push) begin
                mem_q[wptr_q] <= i_wb_data;
            end
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_err     = err_q;
    assign o_wb_cyc  = cyc_q;
    assign o_wb_stb  = stb_q;
    assign o_wb_we   = 1'b0;
    assign o_wb_addr = addr_q;
    assign o_wb_data = '0;
    assign o_valid   = fcnt_q != '0;
    assign o_data    = o_valid ? mem_q[rptr_q] : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        push |-> ((fcnt_q != CW'(DEPTH)) || pop));
    a_no_stb_in_drain: assert property (@(posedge clk) disable iff (reset)
        (state_q == StDrain) |-> !stb_q);
endmodule

// File: tb/tb_wb_fetch_master.sv
// Directed bench for wb_fetch_master: a pipelined Wishbone slave model plus an output
// monitor run on the falling edge; each scenario task checks its own expectations.
module tb_wb_fetch_master;
    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic [31:0] i_base_addr;
    logic [15:0] i_count;
    logic        o_busy, o_done, o_err;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_addr, o_wb_data;
    logic        i_wb_ack   = 1'b0;
    logic        i_wb_stall = 1'b0;
    logic        i_wb_err   = 1'b0;
    logic [31:0] i_wb_data  = 32'h0;
    logic        o_valid;
    logic [31:0] o_data;
    logic        i_ready;

    wb_fetch_master #(.DEPTH(DEPTH), .ADDR_STEP(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_base_addr(i_base_addr),
        .i_count    (i_count),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .i_wb_ack   (i_wb_ack),
        .i_wb_stall (i_wb_stall),
        .i_wb_err   (i_wb_err),
        .i_wb_data  (i_wb_data),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .i_ready    (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scenario configuration, written only by the stimulus process.
    int   clear_gen     = 0;
    logic ack_hold      = 1'b0;
    int   err_resp_idx  = 0;
    int   stall_req_idx = 0;
    int   stall_len     = 0;

    // Slave/monitor state, written only by the falling-edge process.
    int          seen_gen   = 0;
    logic [31:0] pend_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] got[$];
    logic        stall_stb[$];
    logic [31:0] stall_addr[$];
    int          acc_num    = 0;
    int          resp_num   = 0;
    int          done_cnt   = 0;
    int          stall_left = 0;
    logic        stall_on   = 1'b0;
    logic        cyc_seen   = 1'b0;
    logic [31:0] slave_addr;

    int n_checks = 0;
    int n_pass   = 0;

    always @(negedge clk) begin
        if (clear_gen != seen_gen) begin
            seen_gen = clear_gen;
            pend_q.delete();
            acc_log.delete();
            got.delete();
            stall_stb.delete();
            stall_addr.delete();
            acc_num    = 0;
            resp_num   = 0;
            done_cnt   = 0;
            cyc_seen   = 1'b0;
            stall_on   = 1'b0;
            stall_left = stall_len;
        end
        i_wb_ack   = 1'b0;
        i_wb_err   = 1'b0;
        i_wb_data  = 32'h0;
        i_wb_stall = 1'b0;
        if (reset) begin
            pend_q.delete();
            stall_on = 1'b0;
        end else begin
            // Respond one cycle after each accepted request, in order.
            if (pend_q.size() != 0 && !ack_hold) begin
                slave_addr = pend_q.pop_front();
                resp_num++;
                if (resp_num == err_resp_idx) begin
                    i_wb_err = 1'b1;
                end else begin
                    i_wb_ack  = 1'b1;
                    i_wb_data = 32'hDA00_0000 | slave_addr;
                end
            end
            if (stall_left > 0 && acc_num + 1 == stall_req_idx &&
                (stall_on || (o_wb_cyc && o_wb_stb))) begin
                stall_on   = 1'b1;
                stall_left--;
                i_wb_stall = 1'b1;
                stall_stb.push_back(o_wb_stb);
                stall_addr.push_back(o_wb_addr);
            end else begin
                stall_on = 1'b0;
            end
            if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
                pend_q.push_back(o_wb_addr);
                acc_log.push_back(o_wb_addr);
                acc_num++;
            end
            if (o_valid && i_ready) got.push_back(o_data);
            if (o_done) done_cnt++;
            if (o_wb_cyc) cyc_seen = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        clear_gen++;
        @(negedge clk);
        tick();
    endtask

    task automatic do_start(input logic [31:0] base, input logic [15:0] cnt);
        i_base_addr = base;
        i_count     = cnt;
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while (o_busy && k < budget) begin
            tick();
            k++;
        end
        n_checks++;
        if (o_busy !== 1'b0)
            $display("FAIL %s_timeout: o_busy=%b after %0d cycles, required 0", name, o_busy, k);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({o_busy, o_done, o_err, o_wb_cyc, o_wb_stb, o_wb_we, o_valid} !== 7'b0)
            $display("FAIL reset_ctrl: busy/done/err/cyc/stb/we/valid=%b, required 0000000",
                     {o_busy, o_done, o_err, o_wb_cyc, o_wb_stb, o_wb_we, o_valid});
        else n_pass++;
        n_checks++;
        if (o_wb_addr !== 32'h0) $display("FAIL reset_addr: got %h, required 0", o_wb_addr);
        else n_pass++;
        n_checks++;
        if (o_wb_data !== 32'h0) $display("FAIL reset_wdata: got %h, required 0", o_wb_data);
        else n_pass++;
        n_checks++;
        if (o_data !== 32'h0) $display("FAIL reset_data: got %h, required 0", o_data);
        else n_pass++;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic(input string name);
        int bad;
        ack_hold = 1'b0; err_resp_idx = 0; stall_req_idx = 0; stall_len = 0;
        i_ready = 1'b1;
        clear_logs();
        do_start(32'h10, 16'd3);
        n_checks++;
        if ({o_busy, o_wb_cyc, o_wb_stb} !== 3'b111)
            $display("FAIL %s_first: busy/cyc/stb=%b, required 111", name,
                     {o_busy, o_wb_cyc, o_wb_stb});
        else n_pass++;
        n_checks++;
        if (o_wb_addr !== 32'h10)
            $display("FAIL %s_first_addr: got %h, required 00000010", name, o_wb_addr);
        else n_pass++;
        wait_idle(40, name);
        n_checks++;
        if ({o_done, o_wb_cyc, o_wb_stb} !== 3'b100)
            $display("FAIL %s_end: done/cyc/stb=%b, required 100", name,
                     {o_done, o_wb_cyc, o_wb_stb});
        else n_pass++;
        tick();
        n_checks++;
        if (o_done !== 1'b0) $display("FAIL %s_pulse: o_done=%b, required 0", name, o_done);
        else n_pass++;
        repeat (3) tick();
        bad = (acc_log.size() != 3) ? 99 : -1;
        for (int i = 0; i < acc_log.size() && bad < 0; i++)
            if (acc_log[i] !== 32'h10 + 32'(i)) bad = i;
        n_checks++;
        if (bad >= 0)
            $display("FAIL %s_addrs: %0d requests, bad index %0d, required 3 at 10,11,12",
                     name, acc_log.size(), bad);
        else n_pass++;
        bad = (got.size() != 3) ? 99 : -1;
        for (int i = 0; i < got.size() && bad < 0; i++)
            if (got[i] !== (32'hDA00_0010 + 32'(i))) bad = i;
        n_checks++;
        if (bad >= 0)
            $display("FAIL %s_data: %0d words, bad index %0d, required DA000010..DA000012",
                     name, got.size(), bad);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1) $display("FAIL %s_done_cnt: got %0d, required 1", name, done_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int bad;
        ack_hold = 1'b0; err_resp_idx = 0; stall_req_idx = 0; stall_len = 0;
        i_ready = 1'b0;
        clear_logs();
        do_start(32'h100, 16'd8);
        repeat (12) tick();
        n_checks++;
        if (acc_log.size() != DEPTH)
            $display("FAIL bp_window: %0d requests accepted, required %0d", acc_log.size(), DEPTH);
        else n_pass++;
        n_checks++;
        if ({o_wb_stb, o_wb_cyc, o_busy, o_valid} !== 4'b0111)
            $display("FAIL bp_hold: stb/cyc/busy/valid=%b, required 0111",
                     {o_wb_stb, o_wb_cyc, o_busy, o_valid});
        else n_pass++;
        i_ready = 1'b1;
        wait_idle(60, "bp");
        repeat (DEPTH + 2) tick();
        bad = (acc_log.size() != 8) ? 99 : -1;
        for (int i = 0; i < acc_log.size() && bad < 0; i++)
            if (acc_log[i] !== 32'h100 + 32'(i)) bad = i;
        n_checks++;
        if (bad >= 0)
            $display("FAIL bp_addrs: %0d requests, bad index %0d, required 8 from 00000100",
                     acc_log.size(), bad);
        else n_pass++;
        bad = (got.size() != 8) ? 99 : -1;
        for (int i = 0; i < got.size() && bad < 0; i++)
            if (got[i] !== (32'hDA00_0100 + 32'(i))) bad = i;
        n_checks++;
        if (bad >= 0)
            $display("FAIL bp_data: %0d words, bad index %0d, required DA000100..DA000107",
                     got.size(), bad);
        else n_pass++;
    endtask

    task automatic test_stall();
        int bad;
        ack_hold = 1'b0; err_resp_idx = 0; stall_req_idx = 2; stall_len = 5;
        i_ready = 1'b1;
        clear_logs();
        do_start(32'h40, 16'd3);
        wait_idle(40, "stall");
        repeat (3) tick();
        n_checks++;
        if (stall_addr.size() != 5)
            $display("FAIL stall_len: %0d stalled cycles, required 5", stall_addr.size());
        else n_pass++;
        bad = -1;
        for (int i = 0; i < stall_addr.size() && bad < 0; i++)
            if (stall_stb[i] !== 1'b1 || stall_addr[i] !== 32'h41) bad = i;
        n_checks++;
        if (bad >= 0)
            $display("FAIL stall_hold: cycle %0d stb=%b addr=%h, required stb=1 addr=00000041",
                     bad, stall_stb[bad], stall_addr[bad]);
        else n_pass++;
        bad = (acc_log.size() != 3) ? 99 : -1;
        for (int i = 0; i < acc_log.size() && bad < 0; i++)
            if (acc_log[i] !== 32'h40 + 32'(i)) bad = i;
        n_checks++;
        if (bad >= 0)
            $display("FAIL stall_addrs: %0d requests, bad index %0d, required 40,41,42",
                     acc_log.size(), bad);
        else n_pass++;
        n_checks++;
        if (got.size() != 3) $display("FAIL stall_words: got %0d words, required 3", got.size());
        else n_pass++;
    endtask

    task automatic test_error();
        ack_hold = 1'b0; err_resp_idx = 2; stall_req_idx = 0; stall_len = 0;
        i_ready = 1'b1;
        clear_logs();
        do_start(32'h80, 16'd4);
        wait_idle(40, "err");
        n_checks++;
        if ({o_err, o_done, o_wb_cyc, o_wb_stb} !== 4'b1100)
            $display("FAIL err_end: err/done/cyc/stb=%b, required 1100",
                     {o_err, o_done, o_wb_cyc, o_wb_stb});
        else n_pass++;
        repeat (4) tick();
        n_checks++;
        if (o_err !== 1'b1) $display("FAIL err_sticky: o_err=%b, required 1", o_err);
        else n_pass++;
        n_checks++;
        if (got.size() != 1 || got[0] !== 32'hDA00_0080)
            $display("FAIL err_words: %0d words first=%h, required 1 word DA000080",
                     got.size(), (got.size() != 0) ? got[0] : 32'h0);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1) $display("FAIL err_done_cnt: got %0d, required 1", done_cnt);
        else n_pass++;
    endtask

    task automatic test_zero_count();
        ack_hold = 1'b0; err_resp_idx = 0; stall_req_idx = 0; stall_len = 0;
        clear_logs();
        do_start(32'h500, 16'd0);
        n_checks++;
        if ({o_done, o_busy, o_err} !== 3'b100)
            $display("FAIL zero_done: done/busy/err=%b, required 100", {o_done, o_busy, o_err});
        else n_pass++;
        tick();
        n_checks++;
        if (o_done !== 1'b0) $display("FAIL zero_pulse: o_done=%b, required 0", o_done);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (cyc_seen !== 1'b0 || acc_log.size() != 0)
            $display("FAIL zero_cyc: cyc_seen=%b requests=%0d, required 0 and 0",
                     cyc_seen, acc_log.size());
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        int bad;
        ack_hold = 1'b0; err_resp_idx = 0; stall_req_idx = 0; stall_len = 0;
        i_ready = 1'b1;
        clear_logs();
        do_start(32'h200, 16'd2);
        do_start(32'h300, 16'd5);
        wait_idle(40, "busy_start");
        repeat (3) tick();
        bad = (acc_log.size() != 2) ? 99 : -1;
        for (int i = 0; i < acc_log.size() && bad < 0; i++)
            if (acc_log[i] !== 32'h200 + 32'(i)) bad = i;
        n_checks++;
        if (bad >= 0)
            $display("FAIL busy_start_addrs: %0d requests, bad index %0d, required 200,201",
                     acc_log.size(), bad);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1 || got.size() != 2)
            $display("FAIL busy_start_done: done=%0d words=%0d, required 1 and 2",
                     done_cnt, got.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        ack_hold = 1'b1; err_resp_idx = 0; stall_req_idx = 0; stall_len = 0;
        i_ready = 1'b1;
        clear_logs();
        do_start(32'h20, 16'd6);
        repeat (2) tick();
        n_checks++;
        if (acc_log.size() != 2 || o_busy !== 1'b1)
            $display("FAIL rmid_setup: requests=%0d busy=%b, required 2 and 1",
                     acc_log.size(), o_busy);
        else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({o_busy, o_done, o_err, o_wb_cyc, o_wb_stb, o_wb_we, o_valid} !== 7'b0)
            $display("FAIL rmid_ctrl: busy/done/err/cyc/stb/we/valid=%b, required 0000000",
                     {o_busy, o_done, o_err, o_wb_cyc, o_wb_stb, o_wb_we, o_valid});
        else n_pass++;
        n_checks++;
        if (o_wb_addr !== 32'h0 || o_data !== 32'h0)
            $display("FAIL rmid_bus: addr=%h data=%h, required 0 and 0", o_wb_addr, o_data);
        else n_pass++;
        tick();
        reset = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (done_cnt != 0 || o_busy !== 1'b0)
            $display("FAIL rmid_nodone: done pulses=%0d busy=%b, required 0 and 0",
                     done_cnt, o_busy);
        else n_pass++;
        ack_hold = 1'b0;
        test_basic("post_reset");
    endtask

    initial begin
        reset       = 1'b1;
        i_start     = 1'b0;
        i_base_addr = 32'h0;
        i_count     = 16'h0;
        i_ready     = 1'b0;
        test_reset();
        test_basic("basic");
        test_backpressure();
        test_stall();
        test_error();
        test_zero_count();
        test_start_while_busy();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
